// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared constants and state encoding for the UART command parser
package uart_cmd_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         FRAME_LEN     = 6;

   localparam logic [7:0] OP_WR = 8'h01;
   localparam logic [7:0] OP_RD = 8'h02;

   typedef enum logic [2:0] {
      S_HUNT = 3'd0,
      S_OP   = 3'd1,
      S_ADDR = 3'd2,
      S_DHI  = 3'd3,
      S_DLO  = 3'd4,
      S_CHK  = 3'd5
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, cleared only by reset
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - 6-byte host command framer with XOR checksum and valid/ready output
// Optional inter-byte timeout with timeout_err port: define UART_CMD_PARSER_TIMEOUT_EN.
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter int         CNT_W       = 8,
   parameter int         TIMEOUT_CYC = 10_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rx_byte,
   input  logic             rx_vld,
   output logic             cmd_vld,
   input  logic             cmd_rdy,
   output logic [7:0]       cmd_op,
   output logic [7:0]       cmd_addr,
   output logic [15:0]      cmd_data,
   output logic             chk_err,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] ovf_cnt
`ifdef UART_CMD_PARSER_TIMEOUT_EN
   ,
   output logic             timeout_err
`endif
);

   if (TIMEOUT_CYC < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 2");
   end

   state_t     state, state_nxt;
   logic [7:0] op_q, addr_q, dhi_q, dlo_q, chk_acc;
   logic       frm_load, frm_drop, frm_bad, abort;

   always_comb begin
      state_nxt = state;
      frm_load  = 1'b0;
      frm_drop  = 1'b0;
      frm_bad   = 1'b0;
      if (rx_vld) begin
         case (state)
            S_HUNT: if (rx_byte == SYNC_BYTE) state_nxt = S_OP;
            S_OP:   state_nxt = S_ADDR;
            S_ADDR: state_nxt = S_DHI;
            S_DHI:  state_nxt = S_DLO;
            S_DLO:  state_nxt = S_CHK;
            S_CHK: begin
               state_nxt = S_HUNT;
               if (rx_byte != chk_acc)     frm_bad  = 1'b1;
               else if (!cmd_vld || cmd_rdy) frm_load = 1'b1;
               else                          frm_drop = 1'b1;
            end
            default: state_nxt = S_HUNT;
         endcase
      end else if (abort) begin
         state_nxt = S_HUNT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_HUNT;
      else        state <= state_nxt;
   end

   // SYNC itself is excluded from the checksum; only OP..DLO are folded in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         addr_q   <= '0;
         dhi_q    <= '0;
         dlo_q    <= '0;
         chk_acc  <= '0;
         cmd_vld  <= 1'b0;
         cmd_op   <= '0;
         cmd_addr <= '0;
         cmd_data <= '0;
         chk_err  <= 1'b0;
      end else begin
         chk_err <= frm_bad;
         if (rx_vld) begin
            case (state)
               S_HUNT: chk_acc <= '0;
               S_OP:   begin op_q   <= rx_byte; chk_acc <= chk_acc ^ rx_byte; end
               S_ADDR: begin addr_q <= rx_byte; chk_acc <= chk_acc ^ rx_byte; end
               S_DHI:  begin dhi_q  <= rx_byte; chk_acc <= chk_acc ^ rx_byte; end
               S_DLO:  begin dlo_q  <= rx_byte; chk_acc <= chk_acc ^ rx_byte; end
               default: ;
            endcase
         end
         if (frm_load) begin
            cmd_vld  <= 1'b1;
            cmd_op   <= op_q;
            cmd_addr <= addr_q;
            cmd_data <= {dhi_q, dlo_q};
         end else if (cmd_rdy) begin
            cmd_vld  <= 1'b0;
         end
      end
   end

`ifdef UART_CMD_PARSER_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMR_W-1:0] tmr;

   assign abort = (state != S_HUNT) && !rx_vld && (tmr == TMR_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr         <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= abort;
         if (state == S_HUNT || rx_vld || abort) tmr <= '0;
         else                                    tmr <= tmr + 1'b1;
      end
   end
`else
   assign abort = 1'b0;
`endif

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (frm_bad),
      .cnt   (err_cnt)
   );

   sat_counter #(.W(CNT_W)) u_ovf_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (frm_drop),
      .cnt   (ovf_cnt)
   );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser with a frame-level reference model
module tb_uart_cmd_parser;
   import uart_cmd_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_vld = 1'b0;
   logic        cmd_rdy = 1'b0;
   logic        cmd_vld, chk_err;
   logic [7:0]  cmd_op, cmd_addr;
   logic [15:0] cmd_data;
   logic [7:0]  err_cnt, ovf_cnt;
`ifdef UART_CMD_PARSER_TIMEOUT_EN
   logic        timeout_err;
`endif

   uart_cmd_parser #(.TIMEOUT_CYC(100)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_byte  (rx_byte),
      .rx_vld   (rx_vld),
      .cmd_vld  (cmd_vld),
      .cmd_rdy  (cmd_rdy),
      .cmd_op   (cmd_op),
      .cmd_addr (cmd_addr),
      .cmd_data (cmd_data),
      .chk_err  (chk_err),
      .err_cnt  (err_cnt),
      .ovf_cnt  (ovf_cnt)
`ifdef UART_CMD_PARSER_TIMEOUT_EN
      ,
      .timeout_err (timeout_err)
`endif
   );

   always #5 clk = ~clk;

   int          n_chk = 0, n_fail = 0;
   logic [31:0] got_q[$], exp_q[$];
   int          chk_pulses = 0;
   int          bad_m = 0, err_m = 0, ovf_m = 0;
   bit          slot_full = 1'b0;
   int          first_k, to_pulses;

   // Observe completed handshakes and error strobes away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cmd_vld && cmd_rdy) got_q.push_back({cmd_op, cmd_addr, cmd_data});
         if (chk_err) chk_pulses++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Caller is at 1ns after a rising edge; the strobe lasts exactly one cycle.
   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_byte = b;
      rx_vld  = 1'b1;
      tick(1);
      rx_vld  = 1'b0;
      tick(gap);
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] dh,
                             input logic [7:0] dl, input logic [7:0] chk, input int maxgap,
                             input bit rdy_chk, input int lastgap);
      logic [7:0] b[FRAME_LEN];
      b = '{SYNC_BYTE_DEF, op, addr, dh, dl, chk};
      for (int i = 0; i < FRAME_LEN - 1; i++) send_byte(b[i], int'($urandom_range(0, maxgap)));
      cmd_rdy = rdy_chk;
      if (chk !== (op ^ addr ^ dh ^ dl)) begin
         bad_m++;
         if (err_m < 255) err_m++;
      end else if (!slot_full || cmd_rdy) begin
         exp_q.push_back({op, addr, dh, dl});
         slot_full = 1'b1;
      end else if (ovf_m < 255) begin
         ovf_m++;
      end
      if (cmd_rdy) slot_full = 1'b0;
      send_byte(chk, lastgap);
   endtask

   task automatic compare_cmds(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check({tag, "_payload"}, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
      check({tag, "_err_cnt"}, err_cnt, err_m);
      check({tag, "_ovf_cnt"}, ovf_cnt, ovf_m);
      check({tag, "_chk_pulses"}, chk_pulses, bad_m);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_vld"}, cmd_vld, 0);
      check({tag, "_cmd_op"}, cmd_op, 0);
      check({tag, "_cmd_addr"}, cmd_addr, 0);
      check({tag, "_cmd_data"}, cmd_data, 0);
      check({tag, "_chk_err"}, chk_err, 0);
      check({tag, "_err_cnt"}, err_cnt, 0);
      check({tag, "_ovf_cnt"}, ovf_cnt, 0);
   endtask

   initial begin
      logic [7:0] op, addr, dh, dl, good, chk;

      // Power-on reset
      tick(3);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick(2);

      // Good frame, back-to-back bytes: cmd_vld one cycle after CHK, one-cycle handshake
      cmd_rdy = 1'b1;
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37, 0, 1'b1, 0);
      check("good_vld", cmd_vld, 1);
      check("good_op", cmd_op, 8'h01);
      check("good_addr", cmd_addr, 8'h10);
      check("good_data", cmd_data, 16'h1234);
      tick(1);
      check("good_vld_drop", cmd_vld, 0);
      tick(2);
      compare_cmds("good");

      // Bad checksum: one-cycle chk_err, no command
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h00, 2, 1'b1, 0);
      check("bad_chk_err", chk_err, 1);
      check("bad_vld", cmd_vld, 0);
      tick(1);
      check("bad_chk_err_end", chk_err, 0);
      send_frame(OP_WR, 8'h22, 8'hBE, 8'hEF, OP_WR ^ 8'h22 ^ 8'hBE ^ 8'hEF, 2, 1'b1, 2);
      compare_cmds("bad_then_good");

      // Garbage before a frame, then a frame full of SYNC bytes
      send_byte(8'h00, 1);
      send_byte(8'hFF, 0);
      send_byte(8'h5A, 3);
      send_frame(OP_RD, 8'h40, 8'h00, 8'hA5, OP_RD ^ 8'h40 ^ 8'hA5, 1, 1'b1, 2);
      send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 1'b1, 2);
      compare_cmds("resync");

      // Backpressure: first held stable, second dropped
      cmd_rdy = 1'b0;
      send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1, 1'b0, 1);
      check("bp_vld", cmd_vld, 1);
      check("bp_data1", {cmd_op, cmd_addr, cmd_data}, 32'h11223344);
      send_frame(8'h55, 8'h66, 8'h77, 8'h88, 8'h55 ^ 8'h66 ^ 8'h77 ^ 8'h88, 1, 1'b0, 1);
      check("bp_data2", {cmd_op, cmd_addr, cmd_data}, 32'h11223344);
      check("bp_ovf", ovf_cnt, 1);
      cmd_rdy = 1'b1;
      slot_full = 1'b0;
      tick(1);
      check("bp_release_vld", cmd_vld, 0);
      compare_cmds("bp");

      // Held command consumed in the same cycle a new frame loads
      cmd_rdy = 1'b0;
      send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04, 0, 1'b0, 1);
      send_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h05 ^ 8'h06 ^ 8'h07 ^ 8'h08, 0, 1'b1, 0);
      check("swap_vld", cmd_vld, 1);
      check("swap_data", {cmd_op, cmd_addr, cmd_data}, 32'h05060708);
      tick(2);
      compare_cmds("swap");

      // Randomised frames, corruptions, garbage, gaps and backpressure
      for (int n = 0; n < 40; n++) begin
         cmd_rdy = 1'($urandom_range(0, 1));
         if (cmd_rdy) slot_full = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            logic [7:0] g;
            g = 8'($urandom_range(0, 255));
            if (g == SYNC_BYTE_DEF) g = 8'h00;
            send_byte(g, int'($urandom_range(0, 2)));
         end
         op   = 8'($urandom);
         addr = 8'($urandom);
         dh   = 8'($urandom);
         dl   = 8'($urandom);
         good = op ^ addr ^ dh ^ dl;
         chk  = ($urandom_range(0, 3) == 0) ? (good ^ 8'($urandom_range(1, 255))) : good;
         send_frame(op, addr, dh, dl, chk, 3, cmd_rdy, 1);
      end
      cmd_rdy = 1'b1;
      slot_full = 1'b0;
      tick(3);
      compare_cmds("random");

      // Reset mid-frame with a command still held
      cmd_rdy = 1'b0;
      send_frame(8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h9A ^ 8'hBC ^ 8'hDE ^ 8'hF0, 0, 1'b0, 1);
      got_q.delete();
      exp_q.delete();
      send_byte(SYNC_BYTE_DEF, 0);
      send_byte(8'h01, 0);
      send_byte(8'h10, 0);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      tick(2);
      rst_n = 1'b1;
      err_m = 0;
      ovf_m = 0;
      slot_full = 1'b0;
      chk_pulses = 0;
      bad_m = 0;
      cmd_rdy = 1'b1;
      tick(1);
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h37, 1, 1'b1, 2);
      compare_cmds("after_rst");

`ifdef UART_CMD_PARSER_TIMEOUT_EN
      // Partial frame abandoned after the inter-byte timeout
      first_k   = -1;
      to_pulses = 0;
      send_byte(SYNC_BYTE_DEF, 0);
      send_byte(8'h01, 0);
      for (int k = 1; k <= 150; k++) begin
         if (timeout_err) begin
            to_pulses++;
            if (first_k < 0) first_k = k;
         end
         tick(1);
      end
      check("timeout_pulses", to_pulses, 1);
      check("timeout_at", (first_k == 100 || first_k == 101), 1);
      send_frame(8'h02, 8'h30, 8'hCA, 8'hFE, 8'h02 ^ 8'h30 ^ 8'hCA ^ 8'hFE, 1, 1'b1, 2);
      compare_cmds("timeout");
`endif

      // Error counter saturation
      for (int n = 0; n < 260; n++) begin
         op = 8'(n);
         send_frame(op, 8'h5A, 8'h00, 8'hFF, (op ^ 8'h5A ^ 8'hFF) ^ 8'h81, 0, 1'b1, 0);
      end
      tick(2);
      check("sat_err_cnt", err_cnt, 8'hFF);
      compare_cmds("sat");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
